dep_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage dependency checker. It replaces per-stage destination-ID comparison with a registered scoreboard.
- Keeps one pending-write counter per architectural register and one for the condition codes. Counters increment when a writer issues, decrement when it retires, and decrement when a squashed instruction is killed.
- Sits between decode and execute. Produces the decode stall, independent of pipeline depth.

---
 rtl/dep_sb_pkg.sv | 18 +
 rtl/dep_scoreboard_sb_counter.sv | 38 +++
 rtl/dep_scoreboard.sv | 132 +++++++++++++
 tb/tb_dep_scoreboard.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dep_sb_pkg.sv
// Shared types for the decode dependency scoreboard: counter width at default
// sizing and the slot index used for the condition-code counter.
package lc3b_types;
    typedef logic [2:0] lc3b_reg;
endpackage

package dep_sb_pkg;
    import lc3b_types::*;

    localparam int DEF_NUM_REGS     = 2 ** $bits(lc3b_reg);
    localparam int DEF_MAX_INFLIGHT = 3;
    localparam int SB_CNT_W         = $clog2(DEF_MAX_INFLIGHT + 1);

    typedef logic [SB_CNT_W-1:0] sb_count;

    // The CC counter lives one past the last architectural register.
    localparam int CC_IDX = DEF_NUM_REGS;
endpackage

// File: rtl/dep_scoreboard_sb_counter.sv
// One pending-writer counter: net +inc/-dec per edge, clamped at zero, with
// an underflow strobe for the sticky error in the top.
module sb_counter #(
    parameter int CNT_W   = 2,
    parameter int MAX_CNT = 3,
    parameter int DEC_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic [DEC_W-1:0] dec_cnt_i,
    output logic [CNT_W-1:0] count_o,
    output logic             nonzero_o,
    output logic             at_max_o,
    output logic             underflow_o
);
    logic [CNT_W-1:0] count_q, count_d;
    int unsigned      up, down;

    always_comb begin
        up          = 32'(count_q) + 32'(inc_i);
        down        = 32'(dec_cnt_i);
        underflow_o = (down > up);
        count_d     = underflow_o ? '0 : CNT_W'(up - down);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != '0);
    assign at_max_o  = (count_q == CNT_W'(MAX_CNT));
endmodule

// File: rtl/dep_scoreboard.sv
// Decode-stage dependency scoreboard: per-register and CC pending-writer
// counters driving a zero-latency decode stall.
module dep_scoreboard
    import dep_sb_pkg::*;
#(
    parameter int NUM_REGS      = 8,
    parameter int NUM_SRC       = 2,
    parameter int MAX_INFLIGHT  = 3,
    parameter int NUM_KILL      = 2,
    parameter int BYPASS_RETIRE = 0,
    localparam int REG_W        = $clog2(NUM_REGS),
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid,
    input  logic                      issue_go,
    input  logic [NUM_SRC*REG_W-1:0]  issue_sr,
    input  logic [NUM_SRC-1:0]        issue_sr_needed,
    input  logic                      issue_ld_reg,
    input  logic [REG_W-1:0]          issue_dr,
    input  logic                      issue_ld_cc,
    input  logic                      issue_needs_cc,
    input  logic                      retire_valid,
    input  logic                      retire_ld_reg,
    input  logic [REG_W-1:0]          retire_dr,
    input  logic                      retire_ld_cc,
    input  logic [NUM_KILL-1:0]       kill_valid,
    input  logic [NUM_KILL-1:0]       kill_ld_reg,
    input  logic [NUM_KILL*REG_W-1:0] kill_dr,
    input  logic [NUM_KILL-1:0]       kill_ld_cc,
    output logic                      dep_stall,
    output logic                      issue_fire,
    output logic [NUM_REGS-1:0]       pending_mask,
    output logic                      cc_pending,
    output logic                      sb_error
);
    localparam int SLOTS   = NUM_REGS + 1;
    localparam int CC_SLOT = NUM_REGS;
    localparam int DEC_W   = $clog2(NUM_KILL + 2);

    logic [SLOTS-1:0] inc, nonzero, at_max, underflow;
    logic [CNT_W-1:0] count   [SLOTS];
    logic [DEC_W-1:0] dec_cnt [SLOTS];
    logic             data_hz, cc_hz, struct_hz;
    logic             sb_error_q, sb_error_d;

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        sb_counter #(
            .CNT_W   (CNT_W),
            .MAX_CNT (MAX_INFLIGHT),
            .DEC_W   (DEC_W)
        ) u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (inc[s]),
            .dec_cnt_i   (dec_cnt[s]),
            .count_o     (count[s]),
            .nonzero_o   (nonzero[s]),
            .at_max_o    (at_max[s]),
            .underflow_o (underflow[s])
        );
    end

    // Each retire and each kill that names a slot subtracts one from it.
    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            inc[s]     = 1'b0;
            dec_cnt[s] = '0;
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            inc[r] = issue_fire && issue_ld_reg && (issue_dr == REG_W'(r));
            if (retire_valid && retire_ld_reg && (retire_dr == REG_W'(r))) begin
                dec_cnt[r] = dec_cnt[r] + DEC_W'(1);
            end
            for (int k = 0; k < NUM_KILL; k++) begin
                if (kill_valid[k] && kill_ld_reg[k] &&
                    (kill_dr[k*REG_W +: REG_W] == REG_W'(r))) begin
                    dec_cnt[r] = dec_cnt[r] + DEC_W'(1);
                end
            end
        end
        inc[CC_SLOT] = issue_fire && issue_ld_cc;
        if (retire_valid && retire_ld_cc) begin
            dec_cnt[CC_SLOT] = dec_cnt[CC_SLOT] + DEC_W'(1);
        end
        for (int k = 0; k < NUM_KILL; k++) begin
            if (kill_valid[k] && kill_ld_cc[k]) begin
                dec_cnt[CC_SLOT] = dec_cnt[CC_SLOT] + DEC_W'(1);
            end
        end
    end

    // A last outstanding writer retiring this cycle may release the reader early.
    always_comb begin
        logic [REG_W-1:0] src;
        logic             byp;
        data_hz = 1'b0;
        src     = '0;
        byp     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src = issue_sr[i*REG_W +: REG_W];
            byp = (BYPASS_RETIRE != 0) && (count[src] == CNT_W'(1)) &&
                  retire_valid && retire_ld_reg && (retire_dr == src);
            if (issue_sr_needed[i] && nonzero[src] && !byp) begin
                data_hz = 1'b1;
            end
        end
        cc_hz = issue_needs_cc && nonzero[CC_SLOT] &&
                !((BYPASS_RETIRE != 0) && (count[CC_SLOT] == CNT_W'(1)) &&
                  retire_valid && retire_ld_cc);
        struct_hz = (issue_ld_reg && at_max[issue_dr]) ||
                    (issue_ld_cc && at_max[CC_SLOT]);
    end

    assign dep_stall  = issue_valid && (data_hz || cc_hz || struct_hz);
    assign issue_fire = issue_valid && issue_go && !dep_stall;

    assign sb_error_d = sb_error_q || (|underflow);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_error_q <= 1'b0;
        end else begin
            sb_error_q <= sb_error_d;
        end
    end

    assign pending_mask = nonzero[NUM_REGS-1:0];
    assign cc_pending   = nonzero[CC_SLOT];
    assign sb_error     = sb_error_q;
endmodule

// File: tb/tb_dep_scoreboard.sv
// Self-checking bench: each driven cycle pushes its expected outputs, a
// negedge monitor pops and compares them against the selected instance.
module tb_dep_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, issue_go, issue_ld_reg, issue_ld_cc, issue_needs_cc;
    logic [5:0] issue_sr;
    logic [1:0] issue_sr_needed;
    logic [2:0] issue_dr;
    logic       retire_valid, retire_ld_reg, retire_ld_cc;
    logic [2:0] retire_dr;
    logic [1:0] kill_valid, kill_ld_reg, kill_ld_cc;
    logic [5:0] kill_dr;

    logic       stall_a, fire_a, cc_a, err_a;
    logic [7:0] mask_a;
    logic       stall_b, fire_b, cc_b, err_b;
    logic [7:0] mask_b;

    typedef struct {
        string      name;
        bit         sel;
        logic       stall;
        logic       fire;
        logic [7:0] mask;
        logic       cc;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dep_scoreboard #(.BYPASS_RETIRE(0)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_go(issue_go),
        .issue_sr(issue_sr), .issue_sr_needed(issue_sr_needed),
        .issue_ld_reg(issue_ld_reg), .issue_dr(issue_dr), .issue_ld_cc(issue_ld_cc),
        .issue_needs_cc(issue_needs_cc), .retire_valid(retire_valid),
        .retire_ld_reg(retire_ld_reg), .retire_dr(retire_dr), .retire_ld_cc(retire_ld_cc),
        .kill_valid(kill_valid), .kill_ld_reg(kill_ld_reg), .kill_dr(kill_dr),
        .kill_ld_cc(kill_ld_cc), .dep_stall(stall_a), .issue_fire(fire_a),
        .pending_mask(mask_a), .cc_pending(cc_a), .sb_error(err_a)
    );

    dep_scoreboard #(.BYPASS_RETIRE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_go(issue_go),
        .issue_sr(issue_sr), .issue_sr_needed(issue_sr_needed),
        .issue_ld_reg(issue_ld_reg), .issue_dr(issue_dr), .issue_ld_cc(issue_ld_cc),
        .issue_needs_cc(issue_needs_cc), .retire_valid(retire_valid),
        .retire_ld_reg(retire_ld_reg), .retire_dr(retire_dr), .retire_ld_cc(retire_ld_cc),
        .kill_valid(kill_valid), .kill_ld_reg(kill_ld_reg), .kill_dr(kill_dr),
        .kill_ld_cc(kill_ld_cc), .dep_stall(stall_b), .issue_fire(fire_b),
        .pending_mask(mask_b), .cc_pending(cc_b), .sb_error(err_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (!e.sel) begin
                check_val({e.name, ".stall"}, 32'(stall_a), 32'(e.stall));
                check_val({e.name, ".fire"},  32'(fire_a),  32'(e.fire));
                check_val({e.name, ".mask"},  32'(mask_a),  32'(e.mask));
                check_val({e.name, ".cc"},    32'(cc_a),    32'(e.cc));
                check_val({e.name, ".err"},   32'(err_a),   32'(e.err));
            end else begin
                check_val({e.name, ".stall"}, 32'(stall_b), 32'(e.stall));
                check_val({e.name, ".fire"},  32'(fire_b),  32'(e.fire));
                check_val({e.name, ".mask"},  32'(mask_b),  32'(e.mask));
                check_val({e.name, ".cc"},    32'(cc_b),    32'(e.cc));
                check_val({e.name, ".err"},   32'(err_b),   32'(e.err));
            end
        end
    end

    task automatic idle();
        issue_valid = 0; issue_go = 0; issue_sr = '0; issue_sr_needed = '0;
        issue_ld_reg = 0; issue_dr = '0; issue_ld_cc = 0; issue_needs_cc = 0;
        retire_valid = 0; retire_ld_reg = 0; retire_dr = '0; retire_ld_cc = 0;
        kill_valid = '0; kill_ld_reg = '0; kill_dr = '0; kill_ld_cc = '0;
    endtask

    task automatic set_issue(input bit ld, input int dr, input bit lcc, input bit ncc,
                             input bit [1:0] need, input int s0, input int s1);
        issue_valid = 1; issue_go = 1;
        issue_ld_reg = ld; issue_dr = 3'(dr); issue_ld_cc = lcc; issue_needs_cc = ncc;
        issue_sr_needed = need; issue_sr = {3'(s1), 3'(s0)};
    endtask

    task automatic set_retire(input bit ldr, input int dr, input bit lcc);
        retire_valid = 1; retire_ld_reg = ldr; retire_dr = 3'(dr); retire_ld_cc = lcc;
    endtask

    task automatic set_kill(input int port, input bit lr, input int dr, input bit lcc);
        kill_valid[port] = 1'b1; kill_ld_reg[port] = lr; kill_ld_cc[port] = lcc;
        kill_dr[port*3 +: 3] = 3'(dr);
    endtask

    task automatic step(input string name, input bit sel, input logic stall, input logic fire,
                        input logic [7:0] mask, input logic cc, input logic err);
        exp_t x;
        x.name = name; x.sel = sel; x.stall = stall; x.fire = fire;
        x.mask = mask; x.cc = cc; x.err = err;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic reset_cycle();
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        reset_cycle();
        step("reset", 0, 0, 0, 8'h00, 0, 0);

        // RAW on R3 without bypass: stall holds through the retire cycle.
        set_issue(1, 3, 0, 0, 2'b00, 0, 0);              step("add_r3", 0, 0, 1, 8'h00, 0, 0);
        set_issue(0, 0, 0, 0, 2'b01, 3, 0);              step("raw_r3", 0, 1, 0, 8'h08, 0, 0);
        set_issue(0, 0, 0, 0, 2'b01, 3, 0); set_retire(1, 3, 0);
                                                         step("raw_ret", 0, 1, 0, 8'h08, 0, 0);
        set_issue(0, 0, 0, 0, 2'b01, 3, 0);              step("raw_free", 0, 0, 1, 8'h00, 0, 0);

        // Structural limit on R5.
        set_issue(1, 5, 0, 0, 2'b00, 0, 0);              step("r5_1", 0, 0, 1, 8'h00, 0, 0);
        set_issue(1, 5, 0, 0, 2'b00, 0, 0);              step("r5_2", 0, 0, 1, 8'h20, 0, 0);
        set_issue(1, 5, 0, 0, 2'b00, 0, 0);              step("r5_3", 0, 0, 1, 8'h20, 0, 0);
        set_issue(1, 5, 0, 0, 2'b00, 0, 0);              step("r5_full", 0, 1, 0, 8'h20, 0, 0);
        set_issue(1, 5, 0, 0, 2'b00, 0, 0); set_retire(1, 5, 0);
                                                         step("r5_ret", 0, 1, 0, 8'h20, 0, 0);
        set_issue(1, 5, 0, 0, 2'b00, 0, 0);              step("r5_go", 0, 0, 1, 8'h20, 0, 0);
        set_retire(1, 5, 0);                             step("r5_d1", 0, 0, 0, 8'h20, 0, 0);
        set_retire(1, 5, 0);                             step("r5_d2", 0, 0, 0, 8'h20, 0, 0);
        set_retire(1, 5, 0);                             step("r5_d3", 0, 0, 0, 8'h20, 0, 0);
        step("r5_empty", 0, 0, 0, 8'h00, 0, 0);

        // CC hazard released by a kill; double kill on one counter.
        set_issue(0, 0, 1, 0, 2'b00, 0, 0);              step("ld_cc", 0, 0, 1, 8'h00, 0, 0);
        set_issue(0, 0, 0, 1, 2'b00, 0, 0);              step("br_wait", 0, 1, 0, 8'h00, 1, 0);
        set_issue(0, 0, 0, 1, 2'b00, 0, 0); set_kill(0, 0, 0, 1);
                                                         step("br_kill", 0, 1, 0, 8'h00, 1, 0);
        set_issue(0, 0, 0, 1, 2'b00, 0, 0);              step("br_fire", 0, 0, 1, 8'h00, 0, 0);
        set_issue(0, 0, 1, 0, 2'b00, 0, 0);              step("cc_w1", 0, 0, 1, 8'h00, 0, 0);
        set_issue(0, 0, 1, 0, 2'b00, 0, 0);              step("cc_w2", 0, 0, 1, 8'h00, 1, 0);
        set_kill(0, 0, 0, 1); set_kill(1, 0, 0, 1);      step("cc_kill2", 0, 0, 0, 8'h00, 1, 0);
        step("cc_clear", 0, 0, 0, 8'h00, 0, 0);

        // Same-cycle inc/dec, then underflow on an empty counter.
        set_issue(1, 2, 0, 0, 2'b00, 0, 0);              step("r2_inc", 0, 0, 1, 8'h00, 0, 0);
        set_issue(1, 2, 0, 0, 2'b00, 0, 0); set_retire(1, 2, 0);
                                                         step("r2_incdec", 0, 0, 1, 8'h04, 0, 0);
        step("r2_hold", 0, 0, 0, 8'h04, 0, 0);
        set_retire(1, 4, 0);                             step("r4_under", 0, 0, 0, 8'h04, 0, 0);
        step("r4_err", 0, 0, 0, 8'h04, 0, 1);
        set_retire(1, 2, 0);                             step("r2_ret", 0, 0, 0, 8'h04, 0, 1);
        set_issue(1, 6, 0, 0, 2'b00, 0, 0);              step("r6_inc", 0, 0, 1, 8'h00, 0, 1);
        set_kill(1, 1, 6, 0);                            step("r6_kill1", 0, 0, 0, 8'h40, 0, 1);
        step("r6_clear", 0, 0, 0, 8'h00, 0, 1);

        // Read-and-write of R1 in one instruction does not self-stall.
        set_issue(1, 1, 0, 0, 2'b11, 1, 1);              step("self_dep", 0, 0, 1, 8'h00, 0, 1);
        set_issue(0, 0, 1, 0, 2'b00, 0, 0);              step("cc_pre", 0, 0, 1, 8'h02, 0, 1);

        // Reset in the middle of traffic.
        set_issue(1, 7, 0, 0, 2'b00, 0, 0); rst_n = 0;   step("rst_mid", 0, 0, 1, 8'h02, 1, 1);
        rst_n = 1;
        set_issue(0, 0, 0, 1, 2'b11, 1, 7);              step("post_rst", 0, 0, 1, 8'h00, 0, 0);
        step("post_idle", 0, 0, 0, 8'h00, 0, 0);

        // Retire bypass instance.
        reset_cycle();
        step("b_reset", 1, 0, 0, 8'h00, 0, 0);
        set_issue(1, 3, 0, 0, 2'b00, 0, 0);              step("b_add_r3", 1, 0, 1, 8'h00, 0, 0);
        set_issue(0, 0, 0, 0, 2'b10, 0, 3); set_retire(1, 3, 0);
                                                         step("b_byp_r3", 1, 0, 1, 8'h08, 0, 0);
        step("b_idle1", 1, 0, 0, 8'h00, 0, 0);
        set_issue(0, 0, 1, 0, 2'b00, 0, 0);              step("b_ld_cc", 1, 0, 1, 8'h00, 0, 0);
        set_issue(0, 0, 0, 1, 2'b00, 0, 0); set_retire(0, 0, 1);
                                                         step("b_byp_cc", 1, 0, 1, 8'h00, 1, 0);
        step("b_idle2", 1, 0, 0, 8'h00, 0, 0);
        set_issue(1, 3, 0, 0, 2'b00, 0, 0);              step("b_r3_1", 1, 0, 1, 8'h00, 0, 0);
        set_issue(1, 3, 0, 0, 2'b00, 0, 0);              step("b_r3_2", 1, 0, 1, 8'h08, 0, 0);
        set_issue(0, 0, 0, 0, 2'b01, 3, 0); set_retire(1, 3, 0);
                                                         step("b_nobyp", 1, 1, 0, 8'h08, 0, 0);
        step("b_idle3", 1, 0, 0, 8'h08, 0, 0);
        set_issue(0, 0, 0, 0, 2'b01, 3, 0); set_retire(1, 3, 0);
                                                         step("b_byp_last", 1, 0, 1, 8'h08, 0, 0);
        step("b_idle4", 1, 0, 0, 8'h00, 0, 0);

        @(negedge clk);
        #1;
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
